// File: rtl/dec_bin_pkg.sv
// Shared constants, state encoding and width helper for the BCD <-> binary converters.
package dec_bin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VAL    = 4'd3;

    // Smallest n with 2**n >= 10**digits: the minimum binary width for a digits-wide BCD value.
    function automatic int clog2_pow10(input int digits);
        longint p;
        int     n;
        p = 1;
        n = 0;
        for (int i = 0; i < digits; i++) p = p * 10;
        for (int i = 0; i < 64; i++) begin
            if ((longint'(1) << n) < p) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell for reverse double-dabble: subtract 3 when the digit is >= 8.
module bcd_digit_adj
    import dec_bin_pkg::*;
(
    input  logic [3:0] i_d,
    output logic [3:0] o_d
);

    always_comb begin
        o_d = i_d;
        if (i_d >= ADJ_THRESH) o_d = i_d - ADJ_VAL;
    end

endmodule

// File: rtl/dec_to_bin_seq.sv
// Sequential packed-BCD to unsigned binary converter, one reverse double-dabble step per clock.
// Handshake: o_valid rises with o_bin/o_err stable and holds until a rising edge sees i_ready=1.
module dec_to_bin_seq
    import dec_bin_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [4*DIGITS-1:0]   i_bcd,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic                  o_err,
    output logic [BIN_W-1:0]      o_bin,
    output logic [1:0]            o_dbg_state
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int WR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state_q, state_d;
    logic [WR_W-1:0]    wr_q, wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [BIN_W-1:0]   bin_q, bin_d;

    logic [WR_W-1:0]    shifted;
    logic [BCD_W-1:0]   adj_bcd;
    logic [WR_W-1:0]    wr_step;
    logic               digit_bad;

    assign shifted = wr_q >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_d (shifted[BIN_W + 4*g +: 4]),
            .o_d (adj_bcd[4*g +: 4])
        );
    end

    assign wr_step = {adj_bcd, shifted[BIN_W-1:0]};

    always_comb begin
        digit_bad = 1'b0;
        for (int g = 0; g < DIGITS; g++) begin
            if (i_bcd[4*g +: 4] > BCD_MAX) digit_bad = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        bin_d   = bin_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (digit_bad) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        bin_d   = '0;
                    end else begin
                        state_d = SHIFT;
                        wr_d    = {i_bcd, {BIN_W{1'b0}}};
                        cnt_d   = CNT_W'(BIN_W);
                        err_d   = 1'b0;
                    end
                end
            end
            SHIFT: begin
                wr_d  = wr_step;
                cnt_d = cnt_q - CNT_W'(1);
                // Last step: publish the bin field including this cycle's shift.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    bin_d   = wr_step[BIN_W-1:0];
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
        end
    end

    // After the final shift every BCD digit must have drained to zero.
    always @(posedge i_clk) begin
        if (i_rst_n && state_q == SHIFT && cnt_q == CNT_W'(1)) begin
            assert (wr_step[WR_W-1:BIN_W] == '0);
            assert (BIN_W >= clog2_pow10(DIGITS));
        end
    end

    assign o_busy      = (state_q == SHIFT);
    assign o_valid     = valid_q;
    assign o_err       = err_q;
    assign o_bin       = bin_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_dec_to_bin_seq.sv
// Directed + randomized bench for dec_to_bin_seq (2-digit default and a 3-digit instance).
module tb_dec_to_bin_seq;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic [7:0]  bcd;
    logic        ready;
    logic        busy;
    logic        valid;
    logic        err;
    logic [6:0]  bin;
    logic [1:0]  dbg_state;

    logic        start3;
    logic [11:0] bcd3;
    logic        ready3;
    logic        busy3;
    logic        valid3;
    logic        err3;
    logic [9:0]  bin3;
    logic [1:0]  dbg_state3;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    dec_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_bcd       (bcd),
        .i_ready     (ready),
        .o_busy      (busy),
        .o_valid     (valid),
        .o_err       (err),
        .o_bin       (bin),
        .o_dbg_state (dbg_state)
    );

    dec_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut3 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start3),
        .i_bcd       (bcd3),
        .i_ready     (ready3),
        .o_busy      (busy3),
        .o_valid     (valid3),
        .o_err       (err3),
        .o_bin       (bin3),
        .o_dbg_state (dbg_state3)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: decimal value from BCD digits with plain arithmetic.
    function automatic logic [32:0] ref_conv(input logic [15:0] code, input int digits);
        int  v;
        int  mult;
        int  d;
        logic bad;
        v = 0; mult = 1; bad = 1'b0;
        for (int i = 0; i < digits; i++) begin
            d = int'((code >> (4*i)) & 16'hF);
            if (d > 9) bad = 1'b1;
            v += d * mult;
            mult *= 10;
        end
        if (bad) v = 0;
        return {bad, 32'(v)};
    endfunction

    // Pulse start for one edge, return the number of edges until o_valid is seen.
    task automatic launch(input logic [7:0] code, output int lat);
        logic [32:0] r;
        r = ref_conv({8'h00, code}, 2);
        exp_q.push_back(r[31:0]);
        @(negedge clk);
        bcd = code;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcd = $urandom_range(0, 255);
        lat = 1;
        while (!valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_conv(input logic [7:0] code, input string tag);
        int lat;
        logic [32:0] r;
        logic [31:0] e;
        r = ref_conv({8'h00, code}, 2);
        launch(code, lat);
        e = exp_q.pop_front();
        check({tag, "_lat"}, lat, r[32] ? 1 : 8);
        check({tag, "_bin"}, {25'd0, bin}, e);
        check({tag, "_err"}, {31'd0, err}, {31'd0, r[32]});
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, valid}, 0);
    endtask

    task automatic run_conv3(input logic [11:0] code, input string tag);
        int lat;
        logic [32:0] r;
        r = ref_conv({4'h0, code}, 3);
        @(negedge clk);
        bcd3 = code;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        lat = 1;
        while (!valid3 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, r[32] ? 1 : 11);
        check({tag, "_bin"}, {22'd0, bin3}, r[31:0]);
        check({tag, "_err"}, {31'd0, err3}, {31'd0, r[32]});
        ready3 = 1'b1;
        @(negedge clk);
        ready3 = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, valid3}, 0);
    endtask

    initial begin
        int lat;
        checks = 0;
        failures = 0;
        start = 0; bcd = 0; ready = 0;
        start3 = 0; bcd3 = 0; ready3 = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_bin", {25'd0, bin}, 0);
        rst_n = 1;

        // Directed basics and busy during SHIFT
        @(negedge clk);
        bcd = 8'h42; start = 1;
        @(negedge clk);
        start = 0;
        check("busy_shift", {31'd0, busy}, 1);
        lat = 1;
        while (!valid && lat < 40) begin @(negedge clk); lat++; end
        check("d42_lat", lat, 8);
        check("d42_bin", {25'd0, bin}, 42);
        check("d42_err", {31'd0, err}, 0);
        ready = 1;
        @(negedge clk);
        ready = 0;
        check("d42_valid_drop", {31'd0, valid}, 0);

        run_conv(8'h99, "d99");
        run_conv(8'h00, "d00");
        run_conv(8'h3A, "e3a");
        run_conv(8'hF0, "ef0");

        // Full sweep of valid codes
        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                run_conv(8'((t << 4) | o), "sweep");
            end
        end

        // Random codes, including invalid digits
        for (int k = 0; k < 40; k++) run_conv(8'($urandom_range(0, 255)), "rand");

        // Back-pressure with ignored starts in SHIFT and DONE
        @(negedge clk);
        bcd = 8'h42; start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        bcd = 8'h11; start = 1;
        @(negedge clk);
        start = 0;
        lat = 3;
        while (!valid && lat < 40) begin @(negedge clk); lat++; end
        check("bp_lat", lat, 8);
        check("bp_bin", {25'd0, bin}, 42);
        for (int i = 0; i < 5; i++) begin
            bcd = 8'h11;
            start = (i % 2 == 0);
            @(negedge clk);
            check("bp_hold_valid", {31'd0, valid}, 1);
            check("bp_hold_bin", {25'd0, bin}, 42);
            check("bp_hold_busy", {31'd0, busy}, 0);
        end
        start = 1; ready = 1;
        @(negedge clk);
        start = 0; ready = 0;
        check("bp_accept_valid", {31'd0, valid}, 0);
        check("bp_same_edge_start", {31'd0, busy}, 0);
        @(negedge clk);
        check("bp_idle_busy", {31'd0, busy}, 0);
        run_conv(8'h11, "d11");

        // Reset in the third SHIFT cycle
        @(negedge clk);
        bcd = 8'h42; start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_valid", {31'd0, valid}, 0);
        check("arst_err", {31'd0, err}, 0);
        check("arst_bin", {25'd0, bin}, 0);
        @(negedge clk);
        rst_n = 1;
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid) lat++;
        end
        check("arst_no_valid", lat, 0);
        run_conv(8'h07, "d07");

        // Three-digit instance
        run_conv3(12'h999, "w999");
        run_conv3(12'h512, "w512");
        run_conv3(12'h9A1, "w_err");
        for (int k = 0; k < 10; k++) begin
            run_conv3(12'((($urandom_range(0, 9)) << 8) | (($urandom_range(0, 9)) << 4) | $urandom_range(0, 9)), "w_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dec_to_bin_seq.md
Name: dec_to_bin_seq

Overview:
- Sequential decimal-to-binary converter: takes a packed BCD number (for example, two digits keyed in from switches) and returns its unsigned binary value.
- Uses reverse double-dabble: one shift-right plus per-digit correction per clock.
- Sits between the switch/keypad capture logic and the arithmetic datapath.
- It is the inverse path of the board's binary-to-decimal 7-segment display chain.
- Uses a start / valid-ready handshake, so it can sit behind debounced button strobes.

Parameters:
- DIGITS, 2, number of BCD digits at the input (1..4).
- BIN_W, 7, width of the binary result; must be >= ceil(log2(10^DIGITS)) (DIGITS=2 gives 7, DIGITS=3 gives 10, DIGITS=4 gives 14).

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  request strobe; sampled only in IDLE.
- i_bcd  in  4*DIGITS  packed BCD input; digit 0 is in [3:0].
- i_ready  in  1  consumer accepts the result while o_valid=1.
- o_busy  out  1  high in SHIFT.
- o_valid  out  1  result available; held until accepted.
- o_err  out  1  qualifies o_valid: at least one input digit was greater than 9.
- o_bin  out  BIN_W  converted value.

Behaviour:
- Reset (i_rst_n=0, asynchronous): state=IDLE; o_busy=0, o_valid=0, o_err=0, o_bin=0; shift register and counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE with i_start=1:
  - Capture i_bcd.
  - If any digit is greater than 9: next state DONE, o_err=1, o_bin=0. o_valid rises 1 cycle after the start edge.
  - Otherwise: load the working register {bcd[4*DIGITS-1:0], bin[BIN_W-1:0]} = {i_bcd, 0}; load cnt=BIN_W; o_err=0; next state SHIFT.
- SHIFT, each cycle:
  - Logical shift right of the whole working register by 1.
  - Then each 4-bit BCD field that is >= 8 has 3 subtracted (4-bit, no borrow across digits).
  - cnt decrements.
  - When cnt reaches 1, the next state is DONE and o_bin is loaded from the bin field, including the final shift.
- Latency: o_valid rises exactly BIN_W+1 clocks after the edge that sampled i_start (8 clocks for the default).
- DONE:
  - o_valid=1, with o_bin and o_err stable.
  - If i_ready=1 on an edge: o_valid=0 next cycle, state=IDLE.
  - If i_ready=0: hold indefinitely, outputs unchanged.
- i_start is ignored in SHIFT and in DONE, including on the same edge as i_ready; a new request needs IDLE.
- Back-to-back throughput: one conversion per BIN_W+2 cycles minimum.
- o_bin keeps its last value after the handshake until the next conversion completes. It is meaningful only while o_valid=1.
- Arithmetic: unsigned only. After BIN_W shifts with valid input, the BCD field must be all-zero; simulation asserts this.
- Reset mid-SHIFT or mid-DONE aborts immediately. The pending result is discarded and no o_valid is produced.
- i_bcd may change freely after the capture edge.

Decomposition:
- Shared package/header dec_bin_pkg:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - BCD_MAX=4'd9, ADJ_THRESH=4'd8, ADJ_VAL=4'd3.
  - Width helper function clog2_pow10(DIGITS).
- One sub-module, bcd_digit_adj:
  - 4-bit combinational "if >= 8, subtract 3" cell.
  - Instantiated DIGITS times in a generate loop.
  - Can be reused by the forward double-dabble block.

Test Plan:
- Defaults, i_bcd=8'h42, pulse i_start, i_ready=1 -> o_valid high exactly 8 cycles later, o_bin=7'd42, o_err=0, o_valid low the following cycle.
- i_bcd=8'h99 -> o_bin=7'd99. i_bcd=8'h00 -> o_bin=0. Sweep all 100 valid codes and compare against tens*10+ones.
- i_bcd=8'h3A -> o_valid 1 cycle after start, o_err=1, o_bin=0. Also i_bcd=8'hF0 -> o_err=1.
- Back-pressure: i_ready=0 for 5 cycles after o_valid, pulse i_start with i_bcd=8'h11 during SHIFT and during DONE -> o_valid and o_bin (42) stable, no new conversion. Raise i_ready -> IDLE; a new start then yields 11.
- Reset: assert i_rst_n=0 in the 3rd SHIFT cycle -> all outputs 0 asynchronously, no o_valid afterwards. After release, 8'h07 converts to 7.
- DIGITS=3, BIN_W=10: i_bcd=12'h999 -> o_bin=10'd999 after 11 cycles. 12'h512 -> 512.
